alsu_arbiter: RTL and testbench

Shares one ALSU instance between two command requesters. Round-robin arbitration; the winning command is issued into the ALSU's fixed-latency pipeline. Results return in order, tagged with requester ID and an invalid-op flag, through a credit-protected response FIFO. The block sits between the requester front-ends and the ALSU and owns every ALSU input pin.

---
 rtl/alsu_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_alsu_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alsu_arbiter.sv
`timescale 1ns/1ps
// alsu_arbiter
//   Shares a single ALSU between two command requesters. A round-robin
//   arbiter picks one command per cycle and drives it onto the registered
//   ALSU input pins. The ALSU has a fixed latency of two cycles after its
//   pins are driven. A 3-stage tag pipe follows each command through the
//   ALSU, and the result is captured into an in-order response FIFO.
//   Issue is credit-limited: a command is granted only while
//   (FIFO occupancy + commands in flight) < RSP_DEPTH. The FIFO therefore
//   never overflows.
//
// Parameters
//   RSP_DEPTH      response FIFO entries (power of two, >= 4)
//   PRIORITY_INIT  requester favoured by the first contested grant after reset
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   rN_valid/rN_ready/rN_cmd  requester N command handshake (ready is combinational)
//   rN_lock                   requester N arbitration lock (ARB_LOCK_EN only)
//   alsu_*                    registered ALSU input pins (all zero when idle)
//   alsu_out                  ALSU result
//   rsp_valid/rsp_ready       response handshake
//   rsp_data/rsp_id/rsp_err   head-of-FIFO result, requester id, invalid-op flag
//
// Build option
//   ARB_LOCK_EN  when defined, a requester granted with rN_lock=1 keeps the
//                arbiter while it continues to present valid & lock.
module alsu_arbiter #(
    parameter int RSP_DEPTH     = 4,
    parameter int PRIORITY_INIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [15:0] r0_cmd,
    input  logic        r0_lock,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [15:0] r1_cmd,
    input  logic        r1_lock,
    output logic [2:0]  alsu_A,
    output logic [2:0]  alsu_B,
    output logic [2:0]  alsu_opcode,
    output logic        alsu_cin,
    output logic        alsu_serial_in,
    output logic        alsu_direction,
    output logic        alsu_red_op_A,
    output logic        alsu_red_op_B,
    output logic        alsu_bypass_A,
    output logic        alsu_bypass_B,
    input  logic [5:0]  alsu_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [5:0]  rsp_data,
    output logic        rsp_id,
    output logic        rsp_err
);

    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    // last_q = id of the requester granted most recently
    logic                      last_q, last_d;
    logic [15:0]               issue_q, issue_d;
    logic [2:0]                tv_q, tv_d;
    logic [2:0]                tid_q, tid_d;
    logic [2:0]                terr_q, terr_d;
    logic [RSP_DEPTH-1:0][7:0] mem_q, mem_d;
    logic [PTR_W-1:0]          wr_q, wr_d;
    logic [PTR_W-1:0]          rd_q, rd_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    logic [1:0]  inflight;
    logic        can_issue;
    logic        grant0, grant1;
    logic        accept;
    logic        win_id;
    logic [15:0] win_cmd;
    logic        win_err;
    logic        push, pop;
    logic        hold0, hold1;
    logic [7:0]  head;

    assign inflight  = {1'b0, tv_q[0]} + {1'b0, tv_q[1]} + {1'b0, tv_q[2]};
    // Every accepted command owns a FIFO slot from issue until it is popped.
    assign can_issue = ({1'b0, cnt_q} + OCC_W'(inflight)) < OCC_W'(RSP_DEPTH);

`ifdef ARB_LOCK_EN
    typedef enum logic [1:0] {LOCK_NONE, LOCK_R0, LOCK_R1} lock_e;
    lock_e lock_q, lock_d;

    assign hold0 = (lock_q == LOCK_R0) && r0_valid && r0_lock;
    assign hold1 = (lock_q == LOCK_R1) && r1_valid && r1_lock;

    // Lock survives credit stalls: it is only dropped when the owner stops
    // presenting valid & lock, never because no grant was possible.
    always_comb begin
        lock_d = lock_q;
        if (accept && (win_id ? r1_lock : r0_lock)) begin
            lock_d = win_id ? LOCK_R1 : LOCK_R0;
        end else if (!hold0 && !hold1) begin
            lock_d = LOCK_NONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q <= LOCK_NONE;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = r0_lock ^ r1_lock;
    assign hold0 = 1'b0;
    assign hold1 = 1'b0;
`endif

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (can_issue) begin
            if (hold0) begin
                grant0 = 1'b1;
            end else if (hold1) begin
                grant1 = 1'b1;
            end else if (r0_valid && r1_valid) begin
                grant0 = last_q;
                grant1 = ~last_q;
            end else begin
                grant0 = r0_valid;
                grant1 = r1_valid;
            end
        end
    end

    assign r0_ready = grant0;
    assign r1_ready = grant1;
    assign accept   = grant0 | grant1;
    assign win_id   = grant1;
    assign win_cmd  = grant1 ? r1_cmd : r0_cmd;
    // Invalid: reduction on an arithmetic/shift opcode, or opcode 6/7, unless bypassed.
    assign win_err  = ~(win_cmd[14] | win_cmd[15]) &
                      (((win_cmd[12] | win_cmd[13]) & (win_cmd[1] | win_cmd[2])) |
                       (win_cmd[1] & win_cmd[2]));

    assign push      = tv_q[2];
    assign rsp_valid = (cnt_q != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign head      = mem_q[rd_q];

    always_comb begin
        last_d  = accept ? win_id : last_q;
        issue_d = accept ? win_cmd : '0;
        tv_d    = {tv_q[1:0], accept};
        tid_d   = {tid_q[1:0], win_id};
        terr_d  = {terr_q[1:0], win_err & accept};

        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[wr_q] = {alsu_out, tid_q[2], terr_q[2]};
            wr_d        = wr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q  <= (PRIORITY_INIT == 0);
            issue_q <= '0;
            tv_q    <= '0;
            tid_q   <= '0;
            terr_q  <= '0;
            mem_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            last_q  <= last_d;
            issue_q <= issue_d;
            tv_q    <= tv_d;
            tid_q   <= tid_d;
            terr_q  <= terr_d;
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign alsu_opcode    = issue_q[2:0];
    assign alsu_A         = issue_q[5:3];
    assign alsu_B         = issue_q[8:6];
    assign alsu_cin       = issue_q[9];
    assign alsu_serial_in = issue_q[10];
    assign alsu_direction = issue_q[11];
    assign alsu_red_op_A  = issue_q[12];
    assign alsu_red_op_B  = issue_q[13];
    assign alsu_bypass_A  = issue_q[14];
    assign alsu_bypass_B  = issue_q[15];

    assign rsp_data = rsp_valid ? head[7:2] : '0;
    assign rsp_id   = rsp_valid ? head[1]   : 1'b0;
    assign rsp_err  = rsp_valid ? head[0]   : 1'b0;

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (rst) !(push && (cnt_q == CNT_W'(RSP_DEPTH)))
    );

endmodule

// File: tb/tb_alsu_arbiter.sv
`timescale 1ns/1ps
module tb_alsu_arbiter;

    localparam int RSP_DEPTH     = 4;
    localparam int PRIORITY_INIT = 0;
`ifdef ARB_LOCK_EN
    localparam logic LK = 1'b1;
`else
    localparam logic LK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_valid, r0_ready, r0_lock;
    logic        r1_valid, r1_ready, r1_lock;
    logic [15:0] r0_cmd, r1_cmd;
    logic [2:0]  alsu_A, alsu_B, alsu_opcode;
    logic        alsu_cin, alsu_serial_in, alsu_direction;
    logic        alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;
    logic [5:0]  alsu_out;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [5:0]  rsp_data;

    alsu_arbiter #(.RSP_DEPTH(RSP_DEPTH), .PRIORITY_INIT(PRIORITY_INIT)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_cmd(r0_cmd), .r0_lock(r0_lock),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_cmd(r1_cmd), .r1_lock(r1_lock),
        .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode),
        .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in), .alsu_direction(alsu_direction),
        .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
        .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
        .alsu_out(alsu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // ALSU semantics: bypass first, then invalid -> 0, then the opcode.
    function automatic logic is_invalid(input logic [15:0] c);
        logic [2:0] op;
        op = c[2:0];
        if (c[14] || c[15]) return 1'b0;
        return (op >= 3'd6) || ((c[12] || c[13]) && (op >= 3'd2));
    endfunction

    function automatic logic [5:0] alsu_fn(input logic [15:0] c, input logic [5:0] prev);
        logic [2:0] a, b;
        logic [5:0] sa, sb;
        a  = c[5:3];
        b  = c[8:6];
        sa = {{3{a[2]}}, a};
        sb = {{3{b[2]}}, b};
        if (c[14]) return {3'b000, a};
        if (c[15]) return {3'b000, b};
        if (is_invalid(c)) return 6'd0;
        case (c[2:0])
            3'd0:    return c[12] ? {5'd0, |a} : (c[13] ? {5'd0, |b} : {3'd0, a | b});
            3'd1:    return c[12] ? {5'd0, ^a} : (c[13] ? {5'd0, ^b} : {3'd0, a ^ b});
            3'd2:    return sa + sb + {5'd0, c[9]};
            3'd3:    return sa * sb;
            3'd4:    return c[11] ? {prev[4:0], c[10]} : {c[10], prev[5:1]};
            3'd5:    return c[11] ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
            default: return 6'd0;
        endcase
    endfunction

    // Behavioural ALSU: input registers, then result register.
    logic [15:0] alsu_pins, alsu_in_q;
    assign alsu_pins = {alsu_bypass_B, alsu_bypass_A, alsu_red_op_B, alsu_red_op_A,
                        alsu_direction, alsu_serial_in, alsu_cin, alsu_B, alsu_A, alsu_opcode};
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            alsu_in_q <= '0;
            alsu_out  <= '0;
        end else begin
            alsu_in_q <= alsu_pins;
            alsu_out  <= alsu_fn(alsu_in_q, alsu_out);
        end
    end

    typedef struct {
        logic [5:0] data;
        logic       id;
        logic       err;
        int         avail;
    } exp_t;
    typedef struct packed {
        logic [5:0] data;
        logic       id;
        logic       err;
    } pop_t;

    exp_t        exp_q[$];
    pop_t        pop_q[$];
    int          iter, outstanding, n_checks, n_errors;
    int          m_owner;
    logic        m_last, m_prev_acc;
    logic [5:0]  m_prev_res;
    logic [15:0] m_prev_issue;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        outstanding  = 0;
        m_owner      = -1;
        m_last       = (PRIORITY_INIT == 0);
        m_prev_acc   = 1'b0;
        m_prev_res   = '0;
        m_prev_issue = '0;
    endtask

    // One clock cycle: drive, check against the reference, advance the reference.
    task automatic step(input logic v0, input logic [15:0] c0, input logic l0,
                        input logic v1, input logic [15:0] c1, input logic l1,
                        input logic rr);
        logic        can, locked, e0, e1, ev, wid;
        logic [15:0] wcmd;
        exp_t        e;
        @(negedge clk);
        r0_valid = v0; r0_cmd = c0; r0_lock = l0;
        r1_valid = v1; r1_cmd = c1; r1_lock = l1;
        rsp_ready = rr;
        #1;
        iter++;
        can    = (outstanding < RSP_DEPTH);
        locked = 1'b0;
        if (m_owner == 0) locked = v0 && l0;
        if (m_owner == 1) locked = v1 && l1;
        e0 = 1'b0;
        e1 = 1'b0;
        if (can) begin
            if (locked) begin
                e0 = (m_owner == 0);
                e1 = (m_owner == 1);
            end else if (v0 && v1) begin
                if (m_last) e0 = 1'b1; else e1 = 1'b1;
            end else begin
                e0 = v0;
                e1 = v1;
            end
        end
        check("r0_ready", r0_ready, e0);
        check("r1_ready", r1_ready, e1);
        check("alsu_pins", alsu_pins, m_prev_issue);
        ev = (exp_q.size() > 0) && (exp_q[0].avail <= iter);
        check("rsp_valid", rsp_valid, ev);
        if (ev) begin
            check("rsp_data", rsp_data, exp_q[0].data);
            check("rsp_id", rsp_id, exp_q[0].id);
            check("rsp_err", rsp_err, exp_q[0].err);
        end
        if (rsp_valid && rr) pop_q.push_back({rsp_data, rsp_id, rsp_err});
        if (ev && rr) begin
            void'(exp_q.pop_front());
            outstanding--;
        end
        if (e0 || e1) begin
            wid     = e1;
            wcmd    = e1 ? c1 : c0;
            e.data  = alsu_fn(wcmd, m_prev_acc ? m_prev_res : 6'd0);
            e.id    = wid;
            e.err   = is_invalid(wcmd);
            e.avail = iter + 4;
            exp_q.push_back(e);
            outstanding++;
            m_last       = wid;
            m_prev_acc   = 1'b1;
            m_prev_res   = e.data;
            m_prev_issue = wcmd;
`ifdef ARB_LOCK_EN
            if (wid ? l1 : l0) m_owner = wid ? 1 : 0;
            else if (!locked)  m_owner = -1;
`endif
        end else begin
            m_prev_acc   = 1'b0;
            m_prev_issue = '0;
`ifdef ARB_LOCK_EN
            if (!locked) m_owner = -1;
`endif
        end
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, rr);
    endtask

    task automatic wait_pops(input int n, input string tag);
        for (int i = 0; i < 20 && pop_q.size() < n; i++) idle(1, 1'b1);
        if (pop_q.size() < n) check(tag, pop_q.size(), n);
    endtask

    logic gid [6];
    int   ng, nacc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_errors = 0; iter = 0;
        r0_valid = 0; r0_cmd = 0; r0_lock = 0;
        r1_valid = 0; r1_cmd = 0; r1_lock = 0;
        rsp_ready = 0;
        reset_model();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_fields", {rsp_data, rsp_id, rsp_err}, 0);
        check("reset_alsu_pins", alsu_pins, 0);
        rst = 1'b0;

        // contested arbitration straight out of reset
        pop_q.delete();
        ng = 0;
        for (int i = 0; i < 30 && ng < 6; i++) begin
            step(1'b1, 16'h0012, 1'b0, 1'b1, 16'h0051, 1'b0, 1'b1);
            if (r0_ready ^ r1_ready) begin
                gid[ng] = r1_ready;
                ng++;
            end
        end
        check("alt_grants", ng, 6);
        idle(10, 1'b1);
        check("alt_rsp_count", pop_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check("alt_grant_order", gid[i], (PRIORITY_INIT + i) % 2);
            if (i < pop_q.size()) check("alt_rsp_id", pop_q[i].id, (PRIORITY_INIT + i) % 2);
        end

        // ADD 3+2+1 from r0
        pop_q.delete();
        step(1'b1, 16'h029A, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        wait_pops(1, "add_timeout");
        check("add_data", pop_q[0].data, 6'd6);
        check("add_id", pop_q[0].id, 0);
        check("add_err", pop_q[0].err, 0);

        // MULT -4*3 from r1
        pop_q.delete();
        step(1'b0, 16'h0, 1'b0, 1'b1, 16'h00E3, 1'b0, 1'b1);
        wait_pops(1, "mult_timeout");
        check("mult_data", pop_q[0].data, 6'h34);
        check("mult_id", pop_q[0].id, 1);

        // invalid opcode, then the same with bypass_A
        pop_q.delete();
        step(1'b1, 16'h004E, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        wait_pops(1, "inv_timeout");
        check("inv_data", pop_q[0].data, 0);
        check("inv_err", pop_q[0].err, 1);
        pop_q.delete();
        step(1'b1, 16'h404E, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        wait_pops(1, "byp_timeout");
        check("byp_data", pop_q[0].data, 6'h01);
        check("byp_err", pop_q[0].err, 0);

        // back-to-back bypass then shift-left (locked against r1 when enabled)
        if (LK) begin
            step(1'b0, 16'h0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b1);
            idle(6, 1'b1);
        end
        pop_q.delete();
        step(1'b1, 16'h4008, 1'b1, LK, 16'h0001, 1'b0, 1'b1);
        step(1'b1, 16'h0C04, 1'b1, LK, 16'h0001, 1'b0, 1'b1);
        if (LK) check("lock_r1_blocked", r1_ready, 0);
        step(1'b0, 16'h0, 1'b0, LK, 16'h0001, 1'b0, 1'b1);
        if (LK) check("lock_r1_after_release", r1_ready, 1);
        wait_pops(2, "shift_timeout");
        check("shift_first", pop_q[0].data, 6'h01);
        check("shift_second", pop_q[1].data, 6'h03);
        idle(6, 1'b1);

        // response backpressure: credits cap accepts at RSP_DEPTH
        nacc = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 16'($urandom), 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
            if (r0_ready) nacc++;
        end
        check("bp_accepts", nacc, RSP_DEPTH);
        check("bp_stalled", r0_ready, 0);
        for (int i = 0; i < 12; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
        idle(10, 1'b1);
        check("bp_drained", exp_q.size(), 0);

        // asynchronous reset with one queued response and three in flight
        step(1'b1, 16'h029A, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        idle(3, 1'b0);
        step(1'b1, 16'h029A, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 16'h00E3, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b1, 16'h404E, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        r0_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_rsp_fields", {rsp_data, rsp_id, rsp_err}, 0);
        check("midrst_alsu_pins", alsu_pins, 0);
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        pop_q.delete();
        idle(10, 1'b1);
        check("midrst_no_stale", pop_q.size(), 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 3) != 0));
        end
        idle(20, 1'b1);
        check("final_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
